// File: rtl/disk_pkg.sv
// Shared definitions for the Disk II head tracker: FSM states, head range
// and the layout of the floppy request word.
package disk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SETTLE    = 2'd1,
    ST_REQ       = 2'd2,
    ST_WAIT_LOAD = 2'd3
  } state_t;

  localparam int          c_max_halftrack = 69;
  localparam logic [6:0]  c_ht_max        = 7'(c_max_halftrack);

  localparam int c_rt_drive_bit = 7;
  localparam int c_rt_trk_msb   = 5;
  localparam int c_rt_trk_lsb   = 0;

  // Target is {drive, track[5:0]}; bit 6 of the request word stays zero.
  function automatic logic [7:0] pack_req(input logic [6:0] tgt);
    logic [7:0] r;
    r = '0;
    r[c_rt_drive_bit] = tgt[6];
    r[c_rt_trk_msb:c_rt_trk_lsb] = tgt[5:0];
    return r;
  endfunction

endpackage

// File: rtl/disk_stepper.sv
// Head position model: a free-running step tick and a saturating half-track
// register driven by the four stepper magnet phases.
module disk_stepper
  import disk_pkg::*;
#(
  parameter int c_step_bits = 14
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] phase,
  output logic [6:0] ht
);

  logic [c_step_bits-1:0] step_cnt;
  logic                   step_tick;
  logic [1:0]             c_cur;
  logic [1:0]             c_up;
  logic [1:0]             c_dn;
  logic                   move_up;
  logic                   move_dn;

  // Down-counter wraps through zero, so one tick every 2^c_step_bits clocks.
  assign step_tick = (step_cnt == '0);

  assign c_cur   = ht[2:1];
  assign c_up    = c_cur + 2'd1;
  assign c_dn    = c_cur - 2'd1;
  assign move_up = phase[c_up] & ~phase[c_dn];
  assign move_dn = phase[c_dn] & ~phase[c_up];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      step_cnt <= '0;
      ht       <= '0;
    end else begin
      step_cnt <= step_cnt - 1'b1;
      if (step_tick) begin
        if (move_up && (ht != c_ht_max)) begin
          ht <= ht + 7'd1;
        end else if (move_dn && (ht != 7'd0)) begin
          ht <= ht - 7'd1;
        end
      end
    end
  end

endmodule

// File: rtl/disk_track_req.sv
// Issues a one-clock floppy request once the head has settled on a track of a
// loaded drive, and reports whether BRAM holds the track under the head.
//   state        | meaning
//   ST_IDLE      | nothing pending; watch for a target differing from the record
//   ST_SETTLE    | target must stay stable until the settle timer MSB sets
//   ST_REQ       | single-cycle request, record captures the target
//   ST_WAIT_LOAD | waiting for load_done from the ESP32
module disk_track_req
  import disk_pkg::*;
#(
  parameter int c_step_bits   = 14,
  parameter int c_settle_bits = 20
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] phase,
  input  logic       drive_sel,
  input  logic       motor_on,
  input  logic [1:0] floppy_in_drive,
  input  logic       load_done,
  output logic [7:0] floppy_req_type,
  output logic       floppy_req,
  output logic [5:0] track,
  output logic       track_ready
);

  state_t                 state;
  logic [6:0]             ht;
  logic [6:0]             target;
  logic [6:0]             rec;
  logic                   rec_valid;
  logic [6:0]             settle_tgt;
  logic [c_settle_bits:0] settle_cnt;
  logic [1:0]             fid_q;
  logic                   drive_loaded;
  logic                   need;
  logic                   any_insert;
  logic                   rec_eject;

  disk_stepper #(
    .c_step_bits(c_step_bits)
  ) u_stepper (
    .clk   (clk),
    .resetn(resetn),
    .phase (phase),
    .ht    (ht)
  );

  assign target       = {drive_sel, ht[6:1]};
  assign track        = ht[6:1];
  assign drive_loaded = floppy_in_drive[drive_sel];
  assign need         = motor_on & drive_loaded & (~rec_valid | (target != rec));
  assign any_insert   = |(floppy_in_drive & ~fid_q);
  assign rec_eject    = fid_q[rec[6]] & ~floppy_in_drive[rec[6]];

  // Outside REQ the word shows the last request, which the record holds.
  assign floppy_req      = (state == ST_REQ);
  assign floppy_req_type = floppy_req ? pack_req(target) : pack_req(rec);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      rec         <= '0;
      rec_valid   <= 1'b0;
      settle_tgt  <= '0;
      settle_cnt  <= '0;
      fid_q       <= '0;
      track_ready <= 1'b0;
    end else begin
      fid_q <= floppy_in_drive;
      case (state)
        ST_IDLE: begin
          if (!rec_valid || (target != rec)) begin
            track_ready <= 1'b0;
          end
          if (need) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            settle_tgt <= target;
          end
        end
        ST_SETTLE: begin
          if (!motor_on || !drive_loaded) begin
            state <= ST_IDLE;
          end else if (target != settle_tgt) begin
            settle_cnt <= '0;
            settle_tgt <= target;
          end else if (settle_cnt[c_settle_bits]) begin
            state <= ST_REQ;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_REQ: begin
          rec         <= target;
          rec_valid   <= 1'b1;
          track_ready <= 1'b0;
          state       <= ST_WAIT_LOAD;
        end
        ST_WAIT_LOAD: begin
          if (rec_eject) begin
            rec_valid   <= 1'b0;
            track_ready <= 1'b0;
            state       <= ST_IDLE;
          end else if (load_done) begin
            track_ready <= rec_valid & (target == rec);
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // A freshly inserted image must be reloaded even for an unchanged target.
      if (any_insert) begin
        rec_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_disk_track_req.sv
// Directed bench for disk_track_req with shortened step and settle periods.
module tb_disk_track_req;

  localparam int STEP_BITS   = 3;
  localparam int SETTLE_BITS = 5;
  localparam int TICK        = 1 << STEP_BITS;
  localparam int LAT         = (1 << SETTLE_BITS) + 2;
  localparam int BUDGET      = 150;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] phase = '0;
  logic       drive_sel = 1'b0;
  logic       motor_on = 1'b0;
  logic [1:0] floppy_in_drive = '0;
  logic       load_done = 1'b0;
  logic [7:0] floppy_req_type;
  logic       floppy_req;
  logic [5:0] track;
  logic       track_ready;

  int n_checks = 0;
  int n_fail   = 0;

  int         cyc = 0;
  int         last_chg = 0;
  logic [5:0] trk_seen = '0;

  disk_track_req #(
    .c_step_bits  (STEP_BITS),
    .c_settle_bits(SETTLE_BITS)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .phase          (phase),
    .drive_sel      (drive_sel),
    .motor_on       (motor_on),
    .floppy_in_drive(floppy_in_drive),
    .load_done      (load_done),
    .floppy_req_type(floppy_req_type),
    .floppy_req     (floppy_req),
    .track          (track),
    .track_ready    (track_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Remembers the clock edge of the most recent visible head movement.
  always @(negedge clk) begin
    if (track !== trk_seen) last_chg <= cyc;
    trk_seen <= track;
  end

  task automatic wait_req(output int n, output logic seen, output logic [7:0] typ);
    seen = 1'b0;
    typ  = '0;
    n    = 0;
    for (int i = 1; i <= BUDGET; i++) begin
      @(negedge clk);
      if (floppy_req === 1'b1) begin
        seen = 1'b1;
        typ  = floppy_req_type;
        n    = i;
        break;
      end
    end
  endtask

  task automatic pulse_load();
    @(negedge clk);
    load_done = 1'b1;
    @(negedge clk);
    load_done = 1'b0;
  endtask

  // Each listed phase is held for two step ticks; the last one is then held for tail clocks.
  task automatic run_seq(input int n_ph, input int first, input int tail,
                         output int reqs, output logic [7:0] typ, output int lat);
    int         since;
    int         cur;
    logic [5:0] prev;
    reqs  = 0;
    typ   = '0;
    lat   = -1;
    since = 0;
    cur   = first & 3;
    prev  = track;
    for (int k = 0; k < n_ph * TICK * 2 + tail; k++) begin
      if (k < n_ph * TICK * 2) cur = (first + k / (TICK * 2)) & 3;
      phase = 4'(1 << cur);
      @(negedge clk);
      if (track !== prev) since = 0;
      else since++;
      prev = track;
      if (floppy_req === 1'b1) begin
        if (reqs == 0) begin
          typ = floppy_req_type;
          lat = since;
        end
        reqs++;
      end
    end
  endtask

  task automatic test_reset();
    int n; logic seen; logic [7:0] typ;
    resetn = 1'b0;
    phase = '0; drive_sel = 1'b0; motor_on = 1'b1; floppy_in_drive = 2'b01; load_done = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({floppy_req, floppy_req_type, track, track_ready} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b type=%h track=%0d ready=%b, expected all 0",
               floppy_req, floppy_req_type, track, track_ready);
    end
    @(negedge clk);
    resetn = 1'b1;
    wait_req(n, seen, typ);
    n_checks++;
    if (!seen || n != LAT) begin
      n_fail++;
      $display("FAIL reset_first_req_latency: got seen=%b after %0d clocks, expected %0d", seen, n, LAT);
    end
    n_checks++;
    if (typ !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_first_req_type: got %h, expected 00", typ);
    end
    @(negedge clk);
    n_checks++;
    if (floppy_req !== 1'b0) begin
      n_fail++;
      $display("FAIL req_one_cycle: got %b in second cycle, expected 0", floppy_req);
    end
    pulse_load();
    n_checks++;
    if (track_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_after_load: got %b, expected 1", track_ready);
    end
  endtask

  task automatic test_step_up();
    int reqs; logic [7:0] typ; int lat;
    run_seq(4, 1, 60, reqs, typ, lat);
    n_checks++;
    if (track !== 6'd4) begin
      n_fail++;
      $display("FAIL step_up_track: got %0d, expected 4", track);
    end
    n_checks++;
    if (reqs != 1 || typ !== 8'h04) begin
      n_fail++;
      $display("FAIL step_up_req: got %0d requests, type %h, expected 1 request type 04", reqs, typ);
    end
    n_checks++;
    if (lat != LAT) begin
      n_fail++;
      $display("FAIL step_up_latency: got %0d clocks after last step, expected %0d", lat, LAT);
    end
    n_checks++;
    if (track_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL step_up_ready_before_load: got %b, expected 0", track_ready);
    end
    pulse_load();
    n_checks++;
    if (track_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL step_up_ready_after_load: got %b, expected 1", track_ready);
    end
  endtask

  task automatic test_step_down_sat();
    int n; logic seen; logic [7:0] typ; int reqs;
    resetn = 1'b0;
    phase = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    wait_req(n, seen, typ);
    pulse_load();
    phase = 4'b1000;
    reqs = 0;
    repeat (8 * TICK) begin
      @(negedge clk);
      if (floppy_req === 1'b1) reqs++;
    end
    n_checks++;
    if (track !== 6'd0 || reqs != 0) begin
      n_fail++;
      $display("FAIL step_down_sat: got track=%0d requests=%0d, expected track 0 and no request", track, reqs);
    end
    n_checks++;
    if (track_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL step_down_ready: got %b, expected 1", track_ready);
    end
  endtask

  task automatic test_max_sat();
    int reqs; logic [7:0] typ; int lat;
    run_seq(35, 1, 8 * TICK, reqs, typ, lat);
    n_checks++;
    if (track !== 6'd34) begin
      n_fail++;
      $display("FAIL max_sat_track: got %0d, expected 34", track);
    end
    n_checks++;
    if (reqs != 1 || typ !== 8'h22) begin
      n_fail++;
      $display("FAIL max_sat_req: got %0d requests, type %h, expected 1 request type 22", reqs, typ);
    end
    pulse_load();
    n_checks++;
    if (track_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL max_sat_ready: got %b, expected 1", track_ready);
    end
  endtask

  task automatic test_wait_load_step();
    int n; logic seen; logic [7:0] typ;
    phase = 4'b0010;
    wait_req(n, seen, typ);
    n_checks++;
    if (!seen || typ !== 8'h21) begin
      n_fail++;
      $display("FAIL wls_first_req: got seen=%b type %h, expected type 21", seen, typ);
    end
    phase = 4'b0001;
    repeat (3 * TICK) @(negedge clk);
    n_checks++;
    if (track !== 6'd32) begin
      n_fail++;
      $display("FAIL wls_track: got %0d, expected 32", track);
    end
    pulse_load();
    n_checks++;
    if (track_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wls_ready_stale: got %b, expected 0", track_ready);
    end
    wait_req(n, seen, typ);
    n_checks++;
    if (!seen || typ !== 8'h20) begin
      n_fail++;
      $display("FAIL wls_new_req: got seen=%b type %h, expected type 20", seen, typ);
    end
    pulse_load();
    n_checks++;
    if (track_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wls_ready_final: got %b, expected 1", track_ready);
    end
  endtask

  task automatic test_drive_sel();
    int n; logic seen; logic [7:0] typ; int reqs;
    drive_sel = 1'b1;
    reqs = 0;
    repeat (100) begin
      @(negedge clk);
      if (floppy_req === 1'b1) reqs++;
    end
    n_checks++;
    if (reqs != 0 || track_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL drive1_empty: got requests=%0d ready=%b, expected 0 and 0", reqs, track_ready);
    end
    floppy_in_drive = 2'b11;
    wait_req(n, seen, typ);
    n_checks++;
    if (!seen || typ !== 8'hA0) begin
      n_fail++;
      $display("FAIL drive1_req: got seen=%b type %h, expected type a0", seen, typ);
    end
    pulse_load();
    n_checks++;
    if (track_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drive1_ready: got %b, expected 1", track_ready);
    end
  endtask

  task automatic test_eject();
    int n; logic seen; logic [7:0] typ; int reqs;
    drive_sel = 1'b0;
    wait_req(n, seen, typ);
    n_checks++;
    if (!seen || typ !== 8'h20) begin
      n_fail++;
      $display("FAIL eject_pre_req: got seen=%b type %h, expected type 20", seen, typ);
    end
    @(negedge clk);
    floppy_in_drive = 2'b10;
    @(negedge clk);
    n_checks++;
    if (track_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL eject_ready: got %b, expected 0", track_ready);
    end
    reqs = 0;
    load_done = 1'b1;
    repeat (80) begin
      @(negedge clk);
      load_done = 1'b0;
      if (floppy_req === 1'b1) reqs++;
    end
    n_checks++;
    if (reqs != 0 || track_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL eject_idle: got requests=%0d ready=%b, expected 0 and 0", reqs, track_ready);
    end
    floppy_in_drive = 2'b11;
    wait_req(n, seen, typ);
    n_checks++;
    if (!seen || typ !== 8'h20) begin
      n_fail++;
      $display("FAIL eject_reinsert_req: got seen=%b type %h, expected type 20", seen, typ);
    end
    pulse_load();
    n_checks++;
    if (track_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL eject_reinsert_ready: got %b, expected 1", track_ready);
    end
  endtask

  // Head at half-track 65; a drive switch is timed so the REQ cycle ends on a step tick.
  task automatic test_tick_at_req();
    int t_ref; int reqs; int early; int n; logic seen; logic [7:0] typ;
    @(negedge clk);
    #1;
    t_ref = last_chg;
    while (((cyc + 1 - t_ref) % TICK) != ((TICK - LAT % TICK) % TICK)) @(negedge clk);
    drive_sel = 1'b1;
    early = 0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k == LAT - 2) phase = 4'b0010;
      if (k < LAT && floppy_req === 1'b1) early++;
    end
    n_checks++;
    if (early != 0 || floppy_req !== 1'b1 || floppy_req_type !== 8'hA0) begin
      n_fail++;
      $display("FAIL tick_req: got early=%0d req=%b type %h, expected req now with type a0",
               early, floppy_req, floppy_req_type);
    end
    load_done = 1'b1;
    @(negedge clk);
    load_done = 1'b0;
    n_checks++;
    if (floppy_req !== 1'b0 || track !== 6'd33) begin
      n_fail++;
      $display("FAIL tick_post: got req=%b track=%0d, expected 0 and 33", floppy_req, track);
    end
    reqs = 0;
    repeat (60) begin
      @(negedge clk);
      if (floppy_req === 1'b1) reqs++;
    end
    n_checks++;
    if (reqs != 0 || floppy_req_type !== 8'hA0) begin
      n_fail++;
      $display("FAIL load_in_req_ignored: got requests=%0d type %h, expected 0 and a0", reqs, floppy_req_type);
    end
    pulse_load();
    n_checks++;
    if (track_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL tick_ready: got %b, expected 0", track_ready);
    end
    wait_req(n, seen, typ);
    n_checks++;
    if (!seen || typ !== 8'hA1) begin
      n_fail++;
      $display("FAIL tick_new_req: got seen=%b type %h, expected type a1", seen, typ);
    end
    pulse_load();
    n_checks++;
    if (track_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL tick_ready_final: got %b, expected 1", track_ready);
    end
  endtask

  task automatic test_reset_mid_wait();
    int n; logic seen; logic [7:0] typ;
    drive_sel = 1'b0;
    wait_req(n, seen, typ);
    n_checks++;
    if (!seen || typ !== 8'h21) begin
      n_fail++;
      $display("FAIL rmw_req: got seen=%b type %h, expected type 21", seen, typ);
    end
    @(negedge clk);
    phase = '0;
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({floppy_req, floppy_req_type, track, track_ready} !== 16'h0) begin
      n_fail++;
      $display("FAIL rmw_reset_outputs: got req=%b type=%h track=%0d ready=%b, expected all 0",
               floppy_req, floppy_req_type, track, track_ready);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    wait_req(n, seen, typ);
    n_checks++;
    if (!seen || n != LAT || typ !== 8'h00) begin
      n_fail++;
      $display("FAIL rmw_restart: got seen=%b after %0d clocks type %h, expected %0d clocks type 00",
               seen, n, typ, LAT);
    end
    pulse_load();
    n_checks++;
    if (track_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmw_ready: got %b, expected 1", track_ready);
    end
  endtask

  initial begin
    test_reset();
    test_step_up();
    test_step_down_sat();
    test_max_sat();
    test_wait_load_step();
    test_drive_sel();
    test_eject();
    test_tick_at_req();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
